v_mul_sequencer: RTL

- Issue/writeback stage wrapped around the vector multiplier `v_mult` (lanes: 8/16/32-bit; opcodes `mul`/`mulh`/`mulhu`/`mulhsu`).
- Accepts tagged requests over valid/ready, drives the multiplier's registered operand/opcode/precision inputs, and tracks in-flight operations with a latency-matched shift register.
- Collects `mul_out` into an in-order output FIFO with valid/ready.
- Credit accounting guarantees no result is ever dropped under output backpressure.

---
 rtl/v_mul_sequencer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/v_mul_sequencer.sv
// Issue/writeback sequencer around the v_mult vector multiplier: tagged issue,
// latency-matched in-flight tracking, and a credit-protected in-order result FIFO.
module v_mul_sequencer #(
  parameter int FIFO_DEPTH  = 4,
  parameter int MUL_LATENCY = 2,
  parameter int TAG_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_opcode,
  input  logic [1:0]       in_precision,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      mul_operand_a,
  output logic [31:0]      mul_operand_b,
  output logic [1:0]       mul_opcode,
  output logic [1:0]       mul_precision,
  input  logic [31:0]      mul_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err,
  output logic             busy
);

  localparam int STAGES = MUL_LATENCY + 1;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + STAGES + 1);
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

  typedef struct packed {
    logic             valid;
    logic             err;
    logic [TAG_W-1:0] tag;
  } track_t;

  typedef struct packed {
    logic [31:0]      result;
    logic             err;
    logic [TAG_W-1:0] tag;
  } entry_t;

  track_t           track [STAGES];
  entry_t           fifo_mem [FIFO_DEPTH];
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] fifo_count, inflight_count;
  logic [CNT_W:0]   credit_used;
  logic             accept, push, pop, illegal;

  // Credits cover every op from accept until its result is popped, so a
  // capture always finds a free FIFO slot even with out_ready held low.
  assign credit_used = {1'b0, fifo_count} + {1'b0, inflight_count};
  assign in_ready    = !rst && (credit_used < DEPTH_C);
  assign accept      = in_valid && in_ready;
  assign illegal     = (in_precision == 2'b11);
  assign push        = track[STAGES-1].valid;
  assign pop         = out_valid && out_ready;

  // NOTE: every clocked register uses non-blocking assignment so all stages
  // sample their pre-edge neighbours and the shift register advances by one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_operand_a <= '0;
      mul_operand_b <= '0;
      mul_opcode    <= '0;
      mul_precision <= '0;
    end else if (accept) begin
      mul_operand_a <= in_a;
      mul_operand_b <= in_b;
      mul_opcode    <= in_opcode;
      mul_precision <= illegal ? 2'b10 : in_precision;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) track[i] <= '0;
    end else begin
      track[0] <= accept ? track_t'{valid: 1'b1, err: illegal, tag: in_tag} : '0;
      for (int i = 1; i < STAGES; i++) track[i] <= track[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_count <= '0;
      fifo_count     <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
    end else begin
      inflight_count <= inflight_count + CNT_W'(accept) - CNT_W'(push);
      fifo_count     <= fifo_count + CNT_W'(push) - CNT_W'(pop);
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // NOTE: the result storage is deliberately not reset; the count gates what
  // is visible, so stale contents can never reach the outputs.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= entry_t'{
        result: track[STAGES-1].err ? 32'h0 : mul_result,
        err:    track[STAGES-1].err,
        tag:    track[STAGES-1].tag
      };
    end
  end

  assign head       = fifo_mem[rd_ptr];
  assign out_valid  = (fifo_count != '0);
  assign out_result = out_valid ? head.result : '0;
  assign out_tag    = out_valid ? head.tag : '0;
  assign out_err    = out_valid ? head.err : 1'b0;
  assign busy       = (inflight_count != '0) || (fifo_count != '0);

  no_fifo_overflow: assert property (@(posedge clk) disable iff (rst)
    (push && !pop) |-> ({1'b0, fifo_count} < DEPTH_C));

  credit_bound: assert property (@(posedge clk) disable iff (rst)
    credit_used <= DEPTH_C);

endmodule
